simd_lane_alu: RTL

Parametrised, pipelined packed-lane saturating ALU with lane-wise accumulator; successor to the fixed four-byte unsigned/saturated sum units in the processor datapath. It splits a `LANES*LANE_W` operand into independent lanes and adds, subtracts or accumulates them with wrap or saturation. It uses a 2-stage valid/ready pipeline, per-lane carry outputs and sticky saturation flags. It sits beside the ALU as a multi-cycle coprocessor for the packed-arithmetic instructions.

---
 rtl/simd_lane_alu_if.sv | 32 +++
 rtl/simd_lane_alu.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/simd_lane_alu_if.sv
// Operand/result bus for simd_lane_alu: input beat handshake, result handshake,
// accumulator/sticky controls and status.
interface simd_lane_alu_if #(
  parameter int LANE_W = 8,
  parameter int LANES  = 4
);
  localparam int DATA_W = LANES * LANE_W;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [2:0]        mode;
  logic              acc_clr;
  logic              sticky_clr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] res;
  logic [LANES-1:0]  lane_c;
  logic              zero;
  logic [LANES-1:0]  sat_sticky;

  modport master (
    output in_valid, a, b, mode, acc_clr, sticky_clr, out_ready,
    input  in_ready, out_valid, res, lane_c, zero, sat_sticky
  );

  modport slave (
    input  in_valid, a, b, mode, acc_clr, sticky_clr, out_ready,
    output in_ready, out_valid, res, lane_c, zero, sat_sticky
  );
endinterface

// File: rtl/simd_lane_alu.sv
// Two-stage packed-lane wrap/saturating add/sub/accumulate unit.
// SIMD_SIGNED_SAT_EN enables signed saturation for mode 010 (otherwise it runs as USAT).
module simd_lane_alu #(
  parameter int LANE_W = 8,
  parameter int LANES  = 4
) (
  input logic          clk,
  input logic          reset,
  simd_lane_alu_if.slave bus
);
  localparam int DATA_W = LANES * LANE_W;

  localparam logic [2:0] MODE_USAT = 3'b001;
  localparam logic [2:0] MODE_SSAT = 3'b010;
  localparam logic [2:0] MODE_SUBU = 3'b011;
  localparam logic [2:0] MODE_ACC  = 3'b100;

  logic              s1_valid_reg;
  logic [DATA_W-1:0] s1_a_reg;
  logic [DATA_W-1:0] s1_b_reg;
  logic [2:0]        s1_mode_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] res_reg;
  logic [LANES-1:0]  lane_c_reg;
  logic              zero_reg;
  logic [LANES-1:0]  sat_sticky_reg;
  logic [DATA_W-1:0] acc_reg;

  logic              advance;
  logic              commit;
  logic [DATA_W-1:0] acc_old;
  logic [DATA_W-1:0] res_next;
  logic [LANES-1:0]  carry_next;
  logic [LANES-1:0]  sat_next;
  logic [LANES-1:0]  sat_set;

  assign advance = !out_valid_reg || bus.out_ready;
  assign commit  = advance && s1_valid_reg;
  // A clear coincident with an ACC commit makes that commit start from zero.
  assign acc_old = bus.acc_clr ? '0 : acc_reg;
  assign sat_set = commit ? sat_next : '0;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] la, lb, lacc, lres;
      logic [LANE_W:0]   sum_u, diff_u, acc_u;
      logic              lcar, lsat;

      assign la     = s1_a_reg[gi*LANE_W +: LANE_W];
      assign lb     = s1_b_reg[gi*LANE_W +: LANE_W];
      assign lacc   = acc_old[gi*LANE_W +: LANE_W];
      assign sum_u  = {1'b0, la} + {1'b0, lb};
      assign diff_u = {1'b0, la} - {1'b0, lb};
      assign acc_u  = {1'b0, lacc} + {1'b0, la};

`ifdef SIMD_SIGNED_SAT_EN
      logic s_ovf;
      assign s_ovf = (la[LANE_W-1] == lb[LANE_W-1]) && (sum_u[LANE_W-1] != la[LANE_W-1]);
`endif

      always_comb begin
        lres = sum_u[LANE_W-1:0];
        lcar = sum_u[LANE_W];
        lsat = 1'b0;
        case (s1_mode_reg)
`ifdef SIMD_SIGNED_SAT_EN
          MODE_USAT: begin
            if (sum_u[LANE_W]) lres = '1;
            lsat = sum_u[LANE_W];
          end
          MODE_SSAT: begin
            lcar = s_ovf;
            lsat = s_ovf;
            // Overflow only happens when both signs agree, so a's sign picks the rail.
            if (s_ovf) lres = la[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
          end
`else
          MODE_USAT, MODE_SSAT: begin
            if (sum_u[LANE_W]) lres = '1;
            lsat = sum_u[LANE_W];
          end
`endif
          MODE_SUBU: begin
            lres = diff_u[LANE_W] ? '0 : diff_u[LANE_W-1:0];
            lcar = diff_u[LANE_W];
            lsat = diff_u[LANE_W];
          end
          MODE_ACC: begin
            lres = acc_u[LANE_W] ? '1 : acc_u[LANE_W-1:0];
            lcar = acc_u[LANE_W];
            lsat = acc_u[LANE_W];
          end
          default: begin
            lres = sum_u[LANE_W-1:0];
            lcar = sum_u[LANE_W];
          end
        endcase
      end

      assign res_next[gi*LANE_W +: LANE_W] = lres;
      assign carry_next[gi] = lcar;
      assign sat_next[gi]   = lsat;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg   <= 1'b0;
      s1_a_reg       <= '0;
      s1_b_reg       <= '0;
      s1_mode_reg    <= '0;
      out_valid_reg  <= 1'b0;
      res_reg        <= '0;
      lane_c_reg     <= '0;
      zero_reg       <= 1'b0;
      sat_sticky_reg <= '0;
      acc_reg        <= '0;
    end else begin
      if (bus.acc_clr) acc_reg <= '0;
      if (advance) begin
        s1_valid_reg  <= bus.in_valid;
        if (bus.in_valid) begin
          s1_a_reg    <= bus.a;
          s1_b_reg    <= bus.b;
          s1_mode_reg <= bus.mode;
        end
        out_valid_reg <= s1_valid_reg;
        zero_reg      <= s1_valid_reg && (res_next == '0);
        if (s1_valid_reg) begin
          res_reg    <= res_next;
          lane_c_reg <= carry_next;
          if (s1_mode_reg == MODE_ACC) acc_reg <= res_next;
        end
      end
      // New saturation bits are ORed after the clear so a coincident event survives.
      sat_sticky_reg <= (bus.sticky_clr ? '0 : sat_sticky_reg) | sat_set;
    end
  end

  assign bus.in_ready   = advance && !reset;
  assign bus.out_valid  = out_valid_reg;
  assign bus.res        = res_reg;
  assign bus.lane_c     = lane_c_reg;
  assign bus.zero       = zero_reg;
  assign bus.sat_sticky = sat_sticky_reg;
endmodule
